// File: rtl/dmem_access_arbiter.sv
// Data-memory access sequencer: shares one RAM port between the MEM stage and a loader/debug port.
// Optional access timeout is enabled by defining DMEM_TIMEOUT_EN.
module dmem_access_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
`ifdef DMEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT       = 15
`endif
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic                     i_MemReadM,
  input  logic                     i_MemWriteM,
  input  logic [ADDRESS_WIDTH-1:0] i_ALUOutM,
  input  logic [DATA_WIDTH-1:0]    i_WriteDataM,
  input  logic [2:0]               i_MemDataSelM,
  output logic [DATA_WIDTH-1:0]    o_ReadDataM,
  output logic                     o_StallM,
  input  logic                     i_LdReq,
  input  logic                     i_LdWe,
  input  logic [ADDRESS_WIDTH-1:0] i_LdAddr,
  input  logic [DATA_WIDTH-1:0]    i_LdWData,
  output logic                     o_LdGnt,
  output logic                     o_LdDone,
  output logic [DATA_WIDTH-1:0]    o_LdRData,
  output logic                     o_MemEn,
  output logic                     o_MemWe,
  output logic [ADDRESS_WIDTH-1:0] o_MemAddr,
  output logic [DATA_WIDTH-1:0]    o_MemWData,
  output logic [2:0]               o_MemSel,
  input  logic                     i_MemAck,
  input  logic [DATA_WIDTH-1:0]    i_MemRData,
  output logic                     o_MemErr
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    P_ACC  = 3'd1,
    P_DONE = 3'd2,
    L_ACC  = 3'd3,
    L_DONE = 3'd4
  } state_t;

  state_t state;
  logic   r_LastLd;
  logic   pipe_req;
  logic   in_acc;
  logic   timeout_hit;

  assign pipe_req = i_MemReadM | i_MemWriteM;
  assign in_acc   = (state == P_ACC) || (state == L_ACC);

  // Stall and RAM request are forced low while reset is held, even mid-access.
  assign o_StallM = ~i_RST & ((pipe_req & (state != P_DONE)) |
                              (state == L_ACC) | (state == L_DONE));
  assign o_MemEn  = ~i_RST & in_acc;
  assign o_LdGnt  = ~i_RST & (state == L_ACC);

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [CNT_W-1:0] r_TimeCnt;

  assign timeout_hit = in_acc & ~i_MemAck & (r_TimeCnt == CNT_W'(TIMEOUT - 1));

  // Counter is zero on ACC entry because every access is entered from IDLE.
  always_ff @(posedge i_CLK) begin
    if (i_RST || !in_acc) begin
      r_TimeCnt <= '0;
    end else if (!i_MemAck) begin
      r_TimeCnt <= r_TimeCnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state       <= IDLE;
      r_LastLd    <= 1'b0;
      o_MemWe     <= 1'b0;
      o_MemAddr   <= '0;
      o_MemWData  <= '0;
      o_MemSel    <= 3'b000;
      o_ReadDataM <= '0;
      o_LdRData   <= '0;
      o_LdDone    <= 1'b0;
      o_MemErr    <= 1'b0;
    end else begin
      o_LdDone <= 1'b0;
      o_MemErr <= 1'b0;
      case (state)
        IDLE: begin
          // Loader wins a tie only if the pipeline had the last grant.
          if (i_LdReq && (!pipe_req || !r_LastLd)) begin
            state      <= L_ACC;
            o_MemWe    <= i_LdWe;
            o_MemAddr  <= i_LdAddr;
            o_MemWData <= i_LdWData;
            o_MemSel   <= 3'b000;
          end else if (pipe_req) begin
            state      <= P_ACC;
            o_MemWe    <= i_MemWriteM;
            o_MemAddr  <= i_ALUOutM;
            o_MemWData <= i_WriteDataM;
            o_MemSel   <= i_MemDataSelM;
          end
        end
        P_ACC: begin
          if (i_MemAck || timeout_hit) begin
            state       <= P_DONE;
            r_LastLd    <= 1'b0;
            o_ReadDataM <= i_MemAck ? i_MemRData : '0;
            o_MemErr    <= ~i_MemAck;
          end
        end
        L_ACC: begin
          if (i_MemAck || timeout_hit) begin
            state     <= L_DONE;
            r_LastLd  <= 1'b1;
            o_LdRData <= i_MemAck ? i_MemRData : '0;
            o_LdDone  <= 1'b1;
            o_MemErr  <= ~i_MemAck;
          end
        end
        P_DONE:  state <= IDLE;
        L_DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
